// File: rtl/multicycle_controller.sv
// Multi-cycle control FSM for the MIPS-subset datapath.
// Sequences FETCH/DECODE/EXEC/MEM/WB, arbitrates the shared memory port
// through mem_req/mem_ready and counts retired instructions.
// Build option: define ILLEGAL_TRAP_EN to park unsupported instructions in
// TRAP until reset; left undefined they retire as NOPs.
//
// state  | meaning
// FETCH  | request instruction word, load IR and PC+4 on mem_ready
// DECODE | latch op/funct, classify, flag unsupported encodings
// EXEC   | ALU operation, branch/jump PC update, JAL link write
// MEM    | data access for LW/SW, held until mem_ready
// WB     | register file write for ALU ops and LW
// TRAP   | unsupported instruction parked, all strobes low
module multicycle_controller #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       op,
  input  logic [5:0]       funct,
  input  logic             alu_zero,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_write,
  output logic             ir_write,
  output logic             pc_write,
  output logic [1:0]       pc_src,
  output logic             reg_write,
  output logic [1:0]       reg_dst,
  output logic [1:0]       mem_to_reg,
  output logic             alu_src_b,
  output logic [2:0]       alu_op,
  output logic [2:0]       state,
  output logic             illegal,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_t;

  typedef enum logic [3:0] {
    C_ADD, C_SUB, C_SLT, C_JR, C_LW, C_SW, C_ADDI, C_XORI,
    C_BEQ, C_BNE, C_J, C_JAL, C_ILL
  } cls_t;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_XOR = 3'b010;
  localparam logic [2:0] ALU_SLT = 3'b011;

  state_t           r_state;
  state_t           w_next;
  logic [5:0]       r_op;
  logic [5:0]       r_funct;
  logic             r_illegal;
  logic [CNT_W-1:0] r_retired;

  cls_t       w_cls_live;
  cls_t       w_cls;
  logic       w_retire;
  logic       w_mem_req;
  logic       w_mem_write;
  logic       w_ir_write;
  logic       w_pc_write;
  logic [1:0] w_pc_src;
  logic       w_reg_write;
  logic [1:0] w_reg_dst;
  logic [1:0] w_mem_to_reg;
  logic       w_alu_src_b;
  logic [2:0] w_alu_op;

  function automatic cls_t classify(input logic [5:0] f_op, input logic [5:0] f_funct);
    cls_t c;
    c = C_ILL;
    case (f_op)
      6'b000000: begin
        case (f_funct)
          6'b100000: c = C_ADD;
          6'b100010: c = C_SUB;
          6'b101010: c = C_SLT;
          6'b001000: c = C_JR;
          default:   c = C_ILL;
        endcase
      end
      6'b100011: c = C_LW;
      6'b101011: c = C_SW;
      6'b001000: c = C_ADDI;
      6'b001110: c = C_XORI;
      6'b000100: c = C_BEQ;
      6'b000101: c = C_BNE;
      6'b000010: c = C_J;
      6'b000011: c = C_JAL;
      default:   c = C_ILL;
    endcase
    return c;
  endfunction

  // Live classification is only meaningful in DECODE; later states use the latched fields.
  assign w_cls_live = classify(op, funct);
  assign w_cls      = classify(r_op, r_funct);

  // Next-state and per-state strobe decode.
  always_comb begin
    w_next       = r_state;
    w_mem_req    = 1'b0;
    w_mem_write  = 1'b0;
    w_ir_write   = 1'b0;
    w_pc_write   = 1'b0;
    w_pc_src     = 2'b00;
    w_reg_write  = 1'b0;
    w_reg_dst    = 2'b00;
    w_mem_to_reg = 2'b00;
    w_alu_src_b  = 1'b0;
    w_alu_op     = ALU_ADD;
    case (r_state)
      S_FETCH: begin
        w_mem_req = 1'b1;
        if (mem_ready) begin
          w_ir_write = 1'b1;
          w_pc_write = 1'b1;
          w_next     = S_DECODE;
        end
      end
      S_DECODE: begin
`ifdef ILLEGAL_TRAP_EN
        w_next = (w_cls_live == C_ILL) ? S_TRAP : S_EXEC;
`else
        w_next = S_EXEC;
`endif
      end
      S_EXEC: begin
        w_next = S_FETCH;
        case (w_cls)
          C_ADD: begin
            w_alu_op = ALU_ADD;
            w_next   = S_WB;
          end
          C_SUB: begin
            w_alu_op = ALU_SUB;
            w_next   = S_WB;
          end
          C_SLT: begin
            w_alu_op = ALU_SLT;
            w_next   = S_WB;
          end
          C_ADDI: begin
            w_alu_src_b = 1'b1;
            w_alu_op    = ALU_ADD;
            w_next      = S_WB;
          end
          C_XORI: begin
            w_alu_src_b = 1'b1;
            w_alu_op    = ALU_XOR;
            w_next      = S_WB;
          end
          C_LW, C_SW: begin
            w_alu_src_b = 1'b1;
            w_alu_op    = ALU_ADD;
            w_next      = S_MEM;
          end
          C_BEQ, C_BNE: begin
            w_alu_op = ALU_SUB;
            if ((w_cls == C_BEQ) == alu_zero) begin
              w_pc_write = 1'b1;
              w_pc_src   = 2'b01;
            end
          end
          C_J: begin
            w_pc_write = 1'b1;
            w_pc_src   = 2'b10;
          end
          C_JAL: begin
            w_pc_write   = 1'b1;
            w_pc_src     = 2'b10;
            w_reg_write  = 1'b1;
            w_reg_dst    = 2'b10;
            w_mem_to_reg = 2'b10;
          end
          C_JR: begin
            w_pc_write = 1'b1;
            w_pc_src   = 2'b11;
          end
          default: begin
            // unsupported encoding falls through as a NOP
          end
        endcase
      end
      S_MEM: begin
        w_mem_req   = 1'b1;
        w_mem_write = (w_cls == C_SW);
        if (mem_ready) begin
          w_next = (w_cls == C_LW) ? S_WB : S_FETCH;
        end
      end
      S_WB: begin
        w_reg_write = 1'b1;
        w_next      = S_FETCH;
        case (w_cls)
          C_LW: begin
            w_reg_dst    = 2'b00;
            w_mem_to_reg = 2'b01;
          end
          C_ADDI, C_XORI: begin
            w_reg_dst    = 2'b00;
            w_mem_to_reg = 2'b00;
          end
          default: begin
            w_reg_dst    = 2'b01;
            w_mem_to_reg = 2'b00;
          end
        endcase
      end
      S_TRAP: begin
        w_next = S_TRAP;
      end
      default: begin
        w_next = S_FETCH;
      end
    endcase
  end

  assign w_retire = ((r_state == S_EXEC) || (r_state == S_MEM) || (r_state == S_WB)) &&
                    (w_next == S_FETCH);

  // State register, op/funct latch, sticky illegal flag and retire counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_FETCH;
      r_op      <= 6'd0;
      r_funct   <= 6'd0;
      r_illegal <= 1'b0;
      r_retired <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_DECODE) begin
        r_op    <= op;
        r_funct <= funct;
        if (w_cls_live == C_ILL) begin
          r_illegal <= 1'b1;
        end
      end
      if (w_retire) begin
        r_retired <= r_retired + CNT_W'(1);
      end
    end
  end

  // Outputs are held low for the whole reset cycle, so a stalled request drops at once.
  assign mem_req    = w_mem_req    & ~reset;
  assign mem_write  = w_mem_write  & ~reset;
  assign ir_write   = w_ir_write   & ~reset;
  assign pc_write   = w_pc_write   & ~reset;
  assign pc_src     = reset ? 2'b00 : w_pc_src;
  assign reg_write  = w_reg_write  & ~reset;
  assign reg_dst    = reset ? 2'b00 : w_reg_dst;
  assign mem_to_reg = reset ? 2'b00 : w_mem_to_reg;
  assign alu_src_b  = w_alu_src_b  & ~reset;
  assign alu_op     = reset ? 3'b000 : w_alu_op;
  assign state      = reset ? 3'b000 : r_state;
  assign illegal    = r_illegal    & ~reset;
  assign retired    = reset ? '0 : r_retired;

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller: the stimulus side pushes the
// expected per-instruction behaviour, a monitor collects what the DUT did
// between FETCH entries and compares. A narrow counter exercises wrap-around.
module tb_multicycle_controller;

  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic [5:0]       op;
  logic [5:0]       funct;
  logic             alu_zero;
  logic             mem_ready;
  logic             mem_req;
  logic             mem_write;
  logic             ir_write;
  logic             pc_write;
  logic [1:0]       pc_src;
  logic             reg_write;
  logic [1:0]       reg_dst;
  logic [1:0]       mem_to_reg;
  logic             alu_src_b;
  logic [2:0]       alu_op;
  logic [2:0]       state;
  logic             illegal;
  logic [CNT_W-1:0] retired;

  multicycle_controller #(.CNT_W(CNT_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .op         (op),
    .funct      (funct),
    .alu_zero   (alu_zero),
    .mem_ready  (mem_ready),
    .mem_req    (mem_req),
    .mem_write  (mem_write),
    .ir_write   (ir_write),
    .pc_write   (pc_write),
    .pc_src     (pc_src),
    .reg_write  (reg_write),
    .reg_dst    (reg_dst),
    .mem_to_reg (mem_to_reg),
    .alu_src_b  (alu_src_b),
    .alu_op     (alu_op),
    .state      (state),
    .illegal    (illegal),
    .retired    (retired)
  );

  // 100 MHz clock.
  always #5 clk = ~clk;

  typedef struct {
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    int         fs;
    int         ms;
    bit         abort;
  } plan_t;

  typedef struct {
    logic [5:0]       op;
    logic [5:0]       funct;
    int               cycles;
    logic [63:0]      trace;
    logic             pcw;
    logic [1:0]       pcsrc;
    logic             chk_alu;
    logic             chk_srcb;
    logic             srcb;
    logic [2:0]       aluop;
    logic             e_rw;
    logic [1:0]       e_dst;
    logic [1:0]       e_m2r;
    logic             w_rw;
    logic [1:0]       w_dst;
    logic [1:0]       w_m2r;
    int               n_req;
    int               n_memw;
    logic [CNT_W-1:0] ret;
    logic             ill;
  } exp_t;

  plan_t plan_q[$];
  exp_t  exp_q[$];

  int n_chk  = 0;
  int n_fail = 0;

  // Abstract model state: instructions retired since reset and whether any was unsupported.
  logic [CNT_W-1:0] m_ret = '0;
  logic             m_ill = 1'b0;

  logic [11:0] tbl [14] = '{12'h020, 12'h022, 12'h02A, 12'h008, 12'h8C0, 12'hAC0, 12'h200,
                            12'h380, 12'h100, 12'h140, 12'h080, 12'h0C0, 12'hFFF, 12'h001};

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", nm, act, req);
    end
  endtask

  function automatic logic [63:0] tr_push(input logic [63:0] t, input logic [2:0] s);
    return (t << 3) | {61'd0, s + 3'd1};
  endfunction

  // Expected behaviour of one instruction from the ISA rules, then queue it.
  task automatic issue(input plan_t p);
    exp_t e;
    bit   is_mem, is_wb, bad;
    e = '{op: p.op, funct: p.funct, cycles: 0, trace: '0, pcw: 1'b0, pcsrc: 2'b00,
          chk_alu: 1'b0, chk_srcb: 1'b0, srcb: 1'b0, aluop: 3'b000, e_rw: 1'b0,
          e_dst: 2'b00, e_m2r: 2'b00, w_rw: 1'b0, w_dst: 2'b00, w_m2r: 2'b00,
          n_req: 0, n_memw: 0, ret: '0, ill: 1'b0};
    is_mem = 0; is_wb = 0; bad = 0;
    case (p.op)
      6'h00: begin
        case (p.funct)
          6'h20: begin e.chk_alu = 1; e.chk_srcb = 1; e.aluop = 3'd0; is_wb = 1; e.w_dst = 2'd1; end
          6'h22: begin e.chk_alu = 1; e.chk_srcb = 1; e.aluop = 3'd1; is_wb = 1; e.w_dst = 2'd1; end
          6'h2A: begin e.chk_alu = 1; e.chk_srcb = 1; e.aluop = 3'd3; is_wb = 1; e.w_dst = 2'd1; end
          6'h08: begin e.pcw = 1; e.pcsrc = 2'd3; end
          default: bad = 1;
        endcase
      end
      6'h23: begin e.chk_alu = 1; e.chk_srcb = 1; e.srcb = 1; is_mem = 1; is_wb = 1; e.w_m2r = 2'd1; end
      6'h2B: begin e.chk_alu = 1; e.chk_srcb = 1; e.srcb = 1; is_mem = 1; e.n_memw = p.ms + 1; end
      6'h08: begin e.chk_alu = 1; e.chk_srcb = 1; e.srcb = 1; is_wb = 1; end
      6'h0E: begin e.chk_alu = 1; e.chk_srcb = 1; e.srcb = 1; e.aluop = 3'd2; is_wb = 1; end
      6'h04: begin e.chk_alu = 1; e.aluop = 3'd1; e.pcw = p.zero; e.pcsrc = 2'd1; end
      6'h05: begin e.chk_alu = 1; e.aluop = 3'd1; e.pcw = !p.zero; e.pcsrc = 2'd1; end
      6'h02: begin e.pcw = 1; e.pcsrc = 2'd2; end
      6'h03: begin e.pcw = 1; e.pcsrc = 2'd2; e.e_rw = 1; e.e_dst = 2'd2; e.e_m2r = 2'd2; end
      default: bad = 1;
    endcase
    e.w_rw = is_wb;
    for (int k = 0; k <= p.fs; k++) begin e.trace = tr_push(e.trace, 3'd0); e.cycles++; end
    e.trace = tr_push(e.trace, 3'd1); e.cycles++;
    e.trace = tr_push(e.trace, 3'd2); e.cycles++;
    if (is_mem) begin
      for (int k = 0; k <= p.ms; k++) begin e.trace = tr_push(e.trace, 3'd3); e.cycles++; end
    end
    if (is_wb) begin e.trace = tr_push(e.trace, 3'd4); e.cycles++; end
    e.n_req = p.fs + 1 + (is_mem ? p.ms + 1 : 0);
    if (bad) m_ill = 1'b1;
    m_ret = m_ret + 1'b1;
    e.ret = m_ret;
    e.ill = m_ill;
    exp_q.push_back(e);
  endtask

  task automatic add(input logic [5:0] o, input logic [5:0] f, input logic z,
                     input int fs, input int ms, input bit ab);
    plan_t p;
    p = '{op: o, funct: f, zero: z, fs: fs, ms: ms, abort: ab};
    plan_q.push_back(p);
  endtask

  // Monitor: one record per instruction, closed when FETCH is re-entered.
  logic [2:0]  mo_prev;
  bit          mo_act;
  int          o_cycles, o_req, o_memw, o_ir, o_fpcw;
  logic [63:0] o_trace;
  logic        o_pcw, o_srcb, o_erw, o_wrw;
  logic [1:0]  o_pcsrc, o_edst, o_em2r, o_wdst, o_wm2r;
  logic [2:0]  o_aluop;

  task automatic close_record();
    exp_t  e;
    string nm;
    if (exp_q.size() == 0) begin
      chk("unexpected_instr", 64'd1, 64'd0);
      return;
    end
    e  = exp_q.pop_front();
    nm = $sformatf("op%02h_f%02h", e.op, e.funct);
    chk({nm, ".cycles"}, 64'(o_cycles), 64'(e.cycles));
    chk({nm, ".state_trace"}, o_trace, e.trace);
    chk({nm, ".mem_req_cycles"}, 64'(o_req), 64'(e.n_req));
    chk({nm, ".mem_write_cycles"}, 64'(o_memw), 64'(e.n_memw));
    chk({nm, ".ir_write"}, 64'(o_ir), 64'd1);
    chk({nm, ".fetch_pc_write"}, 64'(o_fpcw), 64'd1);
    chk({nm, ".exec_pc_write"}, 64'(o_pcw), 64'(e.pcw));
    if (e.pcw) chk({nm, ".exec_pc_src"}, 64'(o_pcsrc), 64'(e.pcsrc));
    if (e.chk_alu) chk({nm, ".exec_alu_op"}, 64'(o_aluop), 64'(e.aluop));
    if (e.chk_srcb) chk({nm, ".exec_alu_src_b"}, 64'(o_srcb), 64'(e.srcb));
    chk({nm, ".exec_reg_write"}, 64'(o_erw), 64'(e.e_rw));
    if (e.e_rw) begin
      chk({nm, ".exec_reg_dst"}, 64'(o_edst), 64'(e.e_dst));
      chk({nm, ".exec_mem_to_reg"}, 64'(o_em2r), 64'(e.e_m2r));
    end
    chk({nm, ".wb_reg_write"}, 64'(o_wrw), 64'(e.w_rw));
    if (e.w_rw) begin
      chk({nm, ".wb_reg_dst"}, 64'(o_wdst), 64'(e.w_dst));
      chk({nm, ".wb_mem_to_reg"}, 64'(o_wm2r), 64'(e.w_m2r));
    end
    chk({nm, ".retired"}, 64'(retired), 64'(e.ret));
    chk({nm, ".illegal"}, 64'(illegal), 64'(e.ill));
  endtask

  // Sample on the falling edge, away from the active edge and input changes.
  initial begin
    mo_act  = 0;
    mo_prev = 3'd7;
    forever begin
      @(negedge clk);
      if (reset) begin
        mo_act  = 0;
        mo_prev = 3'd7;
      end else begin
        if (state == 3'd0 && mo_prev != 3'd0) begin
          if (mo_act) close_record();
          mo_act = 1;
          o_cycles = 0; o_req = 0; o_memw = 0; o_ir = 0; o_fpcw = 0; o_trace = '0;
          o_pcw = 0; o_pcsrc = 0; o_srcb = 0; o_aluop = 0; o_erw = 0; o_edst = 0; o_em2r = 0;
          o_wrw = 0; o_wdst = 0; o_wm2r = 0;
        end
        if (mo_act) begin
          o_cycles++;
          o_trace = tr_push(o_trace, state);
          if (mem_req) o_req++;
          if (mem_req && mem_write) o_memw++;
          if (ir_write) o_ir++;
          if (state == 3'd0 && pc_write && pc_src == 2'b00) o_fpcw++;
          if (state == 3'd2) begin
            o_pcw = pc_write; o_pcsrc = pc_src; o_srcb = alu_src_b; o_aluop = alu_op;
            o_erw = reg_write; o_edst = reg_dst; o_em2r = mem_to_reg;
          end
          if (state == 3'd4) begin
            o_wrw = reg_write; o_wdst = reg_dst; o_wm2r = mem_to_reg;
          end
        end
        mo_prev = state;
      end
    end
  end

  // One-cycle reset from posedge+1; checks the immediate drop and the clean restart.
  task automatic pulse_reset(input string nm);
    mem_ready = 1'b0;
    reset     = 1'b1;
    exp_q.delete();
    m_ret = '0;
    m_ill = 1'b0;
    #1;
    chk({nm, ".mem_req_during_reset"}, 64'(mem_req), 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    chk({nm, ".state_after"}, 64'(state), 64'd0);
    chk({nm, ".mem_req_after"}, 64'(mem_req), 64'd1);
    chk({nm, ".retired_after"}, 64'(retired), 64'd0);
    chk({nm, ".illegal_after"}, 64'(illegal), 64'd0);
  endtask

  // Driver: steers inputs from the observed state, random where the DUT must ignore them.
  task automatic run_plan();
    logic [2:0] st, last;
    int         fl, ml, guard;
    bit         skip;
    plan_t      cur;
    last  = 3'd7;
    fl    = 0;
    ml    = 0;
    guard = 0;
    cur   = '{op: 6'd0, funct: 6'd0, zero: 1'b0, fs: 0, ms: 0, abort: 1'b0};
    forever begin
      skip = 0;
      st   = state;
      if (st == 3'd0 && last != 3'd0) begin
        if (plan_q.size() == 0) break;
        cur   = plan_q.pop_front();
        issue(cur);
        fl    = cur.fs;
        ml    = cur.ms;
        guard = 0;
      end
      guard++;
      if (guard > 40) begin
        chk("instr_timeout", 64'(guard), 64'd40);
        pulse_reset("timeout_recover");
        last = 3'd7;
        skip = 1;
      end
      if (!skip) begin
        op        = 6'($urandom);
        funct     = 6'($urandom);
        alu_zero  = 1'($urandom);
        mem_ready = 1'($urandom);
        if (st == 3'd0) begin
          mem_ready = (fl == 0);
          if (fl > 0) fl--;
        end else if (st == 3'd1) begin
          op    = cur.op;
          funct = cur.funct;
        end else if (st == 3'd2) begin
          alu_zero = cur.zero;
        end else if (st == 3'd3) begin
          if (cur.abort && ml == cur.ms - 2) begin
            pulse_reset("reset_in_mem_stall");
            last = 3'd7;
            skip = 1;
          end else begin
            mem_ready = (ml == 0);
            if (ml > 0) ml--;
          end
        end
      end
      if (!skip) begin
        last = st;
        @(posedge clk); #1;
      end
    end
    mem_ready = 1'b0;
    @(negedge clk);
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
  endtask

  // Simulation time bound.
  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached with %0d failures so far", n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    int hi;
    reset     = 1'b1;
    op        = 6'd0;
    funct     = 6'd0;
    alu_zero  = 1'b0;
    mem_ready = 1'b0;

    for (int c = 0; c < 2; c++) begin
      @(posedge clk); #1;
      chk("reset.state", 64'(state), 64'd0);
      chk("reset.retired", 64'(retired), 64'd0);
      chk("reset.illegal", 64'(illegal), 64'd0);
      chk("reset.strobes", 64'({mem_req, mem_write, ir_write, pc_write, reg_write, alu_src_b}), 64'd0);
    end
    reset = 1'b0;
    #1;
    chk("post_reset.mem_req", 64'(mem_req), 64'd1);

    // Directed: ALU, load with stalls, branches both ways, jumps, store.
    add(6'h00, 6'h20, 1'b0, 0, 0, 0);
    add(6'h23, 6'h00, 1'b0, 0, 3, 0);
    add(6'h04, 6'h00, 1'b1, 0, 0, 0);
    add(6'h05, 6'h00, 1'b1, 0, 0, 0);
    add(6'h03, 6'h00, 1'b0, 0, 0, 0);
    add(6'h08, 6'h00, 1'b0, 1, 0, 0);
    add(6'h0E, 6'h00, 1'b0, 2, 0, 0);
    add(6'h2B, 6'h00, 1'b0, 0, 2, 0);
    add(6'h02, 6'h00, 1'b0, 0, 0, 0);
    add(6'h00, 6'h08, 1'b0, 0, 0, 0);
    add(6'h00, 6'h22, 1'b0, 0, 0, 0);
    add(6'h00, 6'h2A, 1'b0, 0, 0, 0);
    add(6'h04, 6'h00, 1'b0, 0, 0, 0);
    add(6'h05, 6'h00, 1'b0, 0, 0, 0);
`ifndef ILLEGAL_TRAP_EN
    add(6'h3F, 6'h3F, 1'b0, 0, 0, 0);
    add(6'h00, 6'h00, 1'b0, 1, 0, 0);
    hi = 13;
`else
    hi = 11;
`endif
    add(6'h23, 6'h00, 1'b0, 1, 6, 1);
    for (int i = 0; i < 60; i++) begin
      logic [11:0] ent;
      ent = tbl[$urandom_range(0, hi)];
      add(ent[11:6], ent[5:0], 1'($urandom), $urandom_range(0, 3), $urandom_range(0, 4), 0);
    end
    run_plan();

    // Reset while an instruction fetch is stalled, then one clean instruction.
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      chk("fetch_stall.state", 64'(state), 64'd0);
      chk("fetch_stall.mem_req", 64'(mem_req), 64'd1);
    end
    pulse_reset("reset_in_fetch_stall");
    add(6'h00, 6'h20, 1'b0, 0, 0, 0);
    run_plan();

`ifdef ILLEGAL_TRAP_EN
    // Unsupported opcode parks in TRAP without retiring.
    mem_ready = 1'b1;
    @(posedge clk); #1;
    op        = 6'h3F;
    funct     = 6'h3F;
    mem_ready = 1'b0;
    @(posedge clk); #1;
    for (int c = 0; c < 4; c++) begin
      mem_ready = 1'($urandom);
      op        = 6'($urandom);
      #1;
      chk("trap.state", 64'(state), 64'd5);
      chk("trap.retired", 64'(retired), 64'(m_ret));
      chk("trap.illegal", 64'(illegal), 64'd1);
      chk("trap.strobes", 64'({mem_req, mem_write, ir_write, pc_write, reg_write}), 64'd0);
      @(posedge clk); #1;
    end
    pulse_reset("trap_exit");
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
